// File: rtl/apb_req_master_if.sv
// Bundles the request, response and APB signals of apb_req_master.
// Latency: none; this file only declares wires.
// Backpressure: req_ready/rsp_ready handshakes, pready on the APB side.
//
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata  upstream request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout response channel
//   paddr/pwrite/pwdata/psel/penable                 APB requester outputs
//   prdata/pready/pslverr                            APB completer returns
// Modports: master = the bridge itself, slave = the environment around it.
interface apb_req_master_if #(
  parameter int ADDR_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic              psel;
  logic              penable;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwrite, pwdata, psel, penable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwrite, pwdata, psel, penable
  );
endinterface

// File: rtl/apb_req_master.sv
// Converts single valid/ready requests into APB transfers with an ACCESS timeout.
// Latency: accept at N -> SETUP N+1 -> ACCESS N+2.. -> response one cycle after completion.
// Backpressure: one transfer in flight; RESP holds until rsp_ready, req_ready only in IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    apb_req_master_if.master: request channel in, response channel out,
//          APB requester signals out, completer response in
// Parameters: ADDR_W address width, TIMEOUT ACCESS-cycle limit (0 = never abort),
//             TO_W counter width (TIMEOUT must fit).
module apb_req_master #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  apb_req_master_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  localparam bit              TO_EN  = (TIMEOUT != 0);

  logic [1:0]        state;
  logic              req_ready_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic [31:0]       rsp_rdata_q;
  logic [TO_W-1:0]   to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      to_cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // req_ready is registered, so it rises on the first edge after reset.
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            paddr_q     <= bus.req_addr;
            pwrite_q    <= bus.req_write;
            pwdata_q    <= bus.req_wdata;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            state       <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable_q <= 1'b1;
          to_cnt    <= '0;
          state     <= S_ACCESS;
        end

        S_ACCESS: begin
          // pready wins over the limit, so a completion on the last allowed
          // cycle is reported as a normal transfer.
          if (bus.pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? 32'd0 : bus.prdata;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            state         <= S_RESP;
          end else if (TO_EN && (to_cnt == TO_LIM)) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state         <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_rdata   = rsp_rdata_q;

endmodule
